// File: rtl/slc3_stim_sequencer_if.sv
// Host/loader-side bundle for slc3_stim_sequencer: script writes, run control,
// and the S/Run/Continue drive toward the SLC-3 plus sequencer status.
interface slc3_stim_sequencer_if #(
    parameter int SW_WIDTH  = 16,
    parameter int DEPTH     = 16,
    parameter int CNT_WIDTH = 8
) ();
    localparam int AW = $clog2(DEPTH);
    localparam int EW = 2 + SW_WIDTH + CNT_WIDTH;

    logic                wr_en;
    logic [AW-1:0]       wr_addr;
    logic [EW-1:0]       wr_data;
    logic [AW:0]         n_entries;
    logic                start;
    logic                abort;
    logic [SW_WIDTH-1:0] S;
    logic                Run;
    logic                Continue;
    logic                busy;
    logic                done;
    logic [AW:0]         idx;

    modport master (
        output wr_en, wr_addr, wr_data, n_entries, start, abort,
        input  S, Run, Continue, busy, done, idx
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, n_entries, start, abort,
        output S, Run, Continue, busy, done, idx
    );
endinterface

// File: rtl/slc3_stim_sequencer.sv
// Scripted S/Run/Continue driver for SLC-3 bring-up; keys are active-low.
// Define AUTO_CONTINUE_EN to add a free-running Continue toggle while busy.
module slc3_stim_sequencer #(
    parameter int SW_WIDTH  = 16,
    parameter int DEPTH     = 16,
    parameter int CNT_WIDTH = 8,
    parameter int PULSE_LEN = 2,
    parameter int AUTO_PER  = 3
) (
    input  logic                  Clk,
    input  logic                  Reset,
    slc3_stim_sequencer_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int EW = 2 + SW_WIDTH + CNT_WIDTH;
    localparam int PW = $clog2(PULSE_LEN + 1);
    localparam logic [AW:0] NMAX = (AW+1)'(DEPTH);

    localparam logic [1:0] OP_WAIT  = 2'b00;
    localparam logic [1:0] OP_RUN   = 2'b01;
    localparam logic [1:0] OP_CONT  = 2'b10;
    localparam logic [1:0] OP_SETSW = 2'b11;

    if (PULSE_LEN < 1 || AUTO_PER < 1) begin : g_param_check
        $error("slc3_stim_sequencer: PULSE_LEN and AUTO_PER must be >= 1");
    end

    typedef enum logic [2:0] {IDLE, FETCH, PULSE, GAP, DONE} state_t;

    state_t                state;
    logic [EW-1:0]         mem [DEPTH];
    logic [SW_WIDTH-1:0]   s_q;
    logic                  run_q, cont_q, busy_q, done_q;
    logic [AW:0]           idx_q, n_lat, n_clamp;
    logic [CNT_WIDTH-1:0]  gcnt, cnt_lat;
    logic [PW-1:0]         pcnt;
    logic [EW-1:0]         entry;
    logic [1:0]            e_op;
    logic [SW_WIDTH-1:0]   e_sw;
    logic [CNT_WIDTH-1:0]  e_cnt;

    // Script RAM keeps its contents across reset; writes only land while idle.
    always_ff @(posedge Clk) begin
        if (bus.wr_en && !busy_q)
            mem[bus.wr_addr] <= bus.wr_data;
    end

    assign entry   = mem[idx_q[AW-1:0]];
    assign e_op    = entry[EW-1 -: 2];
    assign e_sw    = entry[CNT_WIDTH +: SW_WIDTH];
    assign e_cnt   = entry[CNT_WIDTH-1:0];
    assign n_clamp = (bus.n_entries > NMAX) ? NMAX : bus.n_entries;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state   <= IDLE;
            s_q     <= '0;
            run_q   <= 1'b1;
            cont_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            idx_q   <= '0;
            n_lat   <= '0;
            gcnt    <= '0;
            cnt_lat <= '0;
            pcnt    <= '0;
        end else if (bus.abort) begin
            state  <= IDLE;
            run_q  <= 1'b1;
            cont_q <= 1'b1;
            busy_q <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state  <= FETCH;
                        n_lat  <= n_clamp;
                        idx_q  <= '0;
                        done_q <= 1'b0;
                        busy_q <= 1'b1;
                    end
                end
                FETCH: begin
                    if (idx_q == n_lat) begin
                        state  <= DONE;
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                    end else begin
                        cnt_lat <= e_cnt;
                        case (e_op)
                            OP_RUN: begin
                                run_q <= 1'b0;
                                pcnt  <= PW'(PULSE_LEN - 1);
                                state <= PULSE;
                            end
                            OP_CONT: begin
                                cont_q <= 1'b0;
                                pcnt   <= PW'(PULSE_LEN - 1);
                                state  <= PULSE;
                            end
                            OP_SETSW: begin
                                // New S gets one settle cycle ahead of its cnt-cycle gap.
                                s_q   <= e_sw;
                                gcnt  <= e_cnt;
                                state <= GAP;
                            end
                            default: begin
                                if (e_cnt == '0) begin
                                    idx_q <= idx_q + 1'b1;
                                end else begin
                                    gcnt  <= e_cnt - 1'b1;
                                    state <= GAP;
                                end
                            end
                        endcase
                    end
                end
                PULSE: begin
                    if (pcnt == '0) begin
                        run_q  <= 1'b1;
                        cont_q <= 1'b1;
                        if (cnt_lat == '0) begin
                            idx_q <= idx_q + 1'b1;
                            state <= FETCH;
                        end else begin
                            gcnt  <= cnt_lat - 1'b1;
                            state <= GAP;
                        end
                    end else begin
                        pcnt <= pcnt - 1'b1;
                    end
                end
                GAP: begin
                    if (gcnt == '0) begin
                        idx_q <= idx_q + 1'b1;
                        state <= FETCH;
                    end else begin
                        gcnt <= gcnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef AUTO_CONTINUE_EN
    localparam int APW = $clog2(AUTO_PER + 1);
    logic           auto_t;
    logic [APW-1:0] acnt;
    logic           finishing;

    // Held high whenever the script is not running, including the edge into DONE.
    assign finishing = (state == FETCH) && (idx_q == n_lat);

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            auto_t <= 1'b1;
            acnt   <= '0;
        end else if (!busy_q || bus.abort || finishing) begin
            auto_t <= 1'b1;
            acnt   <= '0;
        end else if (acnt == APW'(AUTO_PER - 1)) begin
            auto_t <= ~auto_t;
            acnt   <= '0;
        end else begin
            acnt <= acnt + 1'b1;
        end
    end

    assign bus.Continue = cont_q & auto_t;
`else
    assign bus.Continue = cont_q;
`endif

    assign bus.S    = s_q;
    assign bus.Run  = run_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.idx  = idx_q;
endmodule

// File: tb/tb_slc3_stim_sequencer.sv
// Directed bench for slc3_stim_sequencer: cycle table for the reference script,
// plus hand sequences for empty script, abort, async reset and busy lockout.
module tb_slc3_stim_sequencer;
    logic clk;
    logic rst_n;
    int   n_cmp  = 0;
    int   n_fail = 0;

    slc3_stim_sequencer_if #(.SW_WIDTH(16), .DEPTH(16), .CNT_WIDTH(8)) bus ();

    slc3_stim_sequencer #(
        .SW_WIDTH(16), .DEPTH(16), .CNT_WIDTH(8), .PULSE_LEN(2), .AUTO_PER(3)
    ) dut (
        .Clk   (clk),
        .Reset (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int          cyc;
        logic [15:0] s;
        logic        run;
        logic        cont;
        logic        busy;
        logic        done;
        logic [4:0]  idx;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_entry(input logic [3:0] a, input logic [1:0] op,
                               input logic [15:0] sw, input logic [7:0] cnt);
        bus.wr_en   = 1'b1;
        bus.wr_addr = a;
        bus.wr_data = {op, sw, cnt};
        step();
        bus.wr_en   = 1'b0;
    endtask

    // Drives start for one cycle (cycle 0); returns at cycle 1.
    task automatic launch(input logic [4:0] n);
        bus.n_entries = n;
        bus.start     = 1'b1;
        step();
        bus.start     = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc, input string name);
        int k;
        k = 0;
        while (bus.done !== 1'b1 && k < max_cyc) begin
            step();
            k++;
        end
        chk({name, "_done_within_bound"}, {31'd0, bus.done}, 32'd1);
    endtask

    initial begin
        // Cycle-by-cycle expectations for {SETSW 000B cnt2; RUN cnt3; CONT cnt0}.
        vecs[0]  = '{1,  16'h0000, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0};
        vecs[1]  = '{2,  16'h000B, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0};
        vecs[2]  = '{3,  16'h000B, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0};
        vecs[3]  = '{4,  16'h000B, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0};
        vecs[4]  = '{5,  16'h000B, 1'b1, 1'b1, 1'b1, 1'b0, 5'd1};
        vecs[5]  = '{6,  16'h000B, 1'b0, 1'b1, 1'b1, 1'b0, 5'd1};
        vecs[6]  = '{7,  16'h000B, 1'b0, 1'b1, 1'b1, 1'b0, 5'd1};
        vecs[7]  = '{8,  16'h000B, 1'b1, 1'b1, 1'b1, 1'b0, 5'd1};
        vecs[8]  = '{9,  16'h000B, 1'b1, 1'b1, 1'b1, 1'b0, 5'd1};
        vecs[9]  = '{10, 16'h000B, 1'b1, 1'b1, 1'b1, 1'b0, 5'd1};
        vecs[10] = '{11, 16'h000B, 1'b1, 1'b1, 1'b1, 1'b0, 5'd2};
        vecs[11] = '{12, 16'h000B, 1'b1, 1'b0, 1'b1, 1'b0, 5'd2};
        vecs[12] = '{13, 16'h000B, 1'b1, 1'b0, 1'b1, 1'b0, 5'd2};
        vecs[13] = '{14, 16'h000B, 1'b1, 1'b1, 1'b1, 1'b0, 5'd3};
        vecs[14] = '{15, 16'h000B, 1'b1, 1'b1, 1'b0, 1'b1, 5'd3};
        vecs[15] = '{16, 16'h000B, 1'b1, 1'b1, 1'b0, 1'b1, 5'd3};

        rst_n         = 1'b0;
        bus.wr_en     = 1'b0;
        bus.wr_addr   = '0;
        bus.wr_data   = '0;
        bus.n_entries = '0;
        bus.start     = 1'b0;
        bus.abort     = 1'b0;
        step();
        step();

        // Reset state
        chk("rst_S",    {16'd0, bus.S},         32'h0);
        chk("rst_Run",  {31'd0, bus.Run},       32'h1);
        chk("rst_Cont", {31'd0, bus.Continue},  32'h1);
        chk("rst_busy", {31'd0, bus.busy},      32'h0);
        chk("rst_done", {31'd0, bus.done},      32'h0);
        chk("rst_idx",  {27'd0, bus.idx},       32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Reference script, table-driven
        write_entry(4'd0, 2'b11, 16'h000B, 8'd2);
        write_entry(4'd1, 2'b01, 16'h0000, 8'd3);
        write_entry(4'd2, 2'b10, 16'h0000, 8'd0);
        launch(5'd3);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("t2_c%0d_S",    vecs[i].cyc), {16'd0, bus.S},        {16'd0, vecs[i].s});
            chk($sformatf("t2_c%0d_Run",  vecs[i].cyc), {31'd0, bus.Run},      {31'd0, vecs[i].run});
            chk($sformatf("t2_c%0d_Cont", vecs[i].cyc), {31'd0, bus.Continue}, {31'd0, vecs[i].cont});
            chk($sformatf("t2_c%0d_busy", vecs[i].cyc), {31'd0, bus.busy},     {31'd0, vecs[i].busy});
            chk($sformatf("t2_c%0d_done", vecs[i].cyc), {31'd0, bus.done},     {31'd0, vecs[i].done});
            chk($sformatf("t2_c%0d_idx",  vecs[i].cyc), {27'd0, bus.idx},      {27'd0, vecs[i].idx});
            step();
        end

        // Empty script: done two cycles after start, keys untouched
        launch(5'd0);
        chk("t3_c1_busy", {31'd0, bus.busy}, 32'h1);
        chk("t3_c1_done", {31'd0, bus.done}, 32'h0);
        chk("t3_c1_keys", {30'd0, bus.Run, bus.Continue}, 32'h3);
        step();
        chk("t3_c2_done", {31'd0, bus.done}, 32'h1);
        chk("t3_c2_busy", {31'd0, bus.busy}, 32'h0);
        chk("t3_c2_keys", {30'd0, bus.Run, bus.Continue}, 32'h3);

        // Abort during the Run pulse, with start in the same cycle
        write_entry(4'd0, 2'b11, 16'h1234, 8'd2);
        launch(5'd3);
        chk("t4_c1_done_cleared", {31'd0, bus.done}, 32'h0);
        for (int i = 0; i < 5; i++) step();
        chk("t4_c6_Run_low", {31'd0, bus.Run}, 32'h0);
        bus.abort = 1'b1;
        bus.start = 1'b1;
        step();
        bus.abort = 1'b0;
        bus.start = 1'b0;
        chk("t4_Run_released", {31'd0, bus.Run},      32'h1);
        chk("t4_Cont",         {31'd0, bus.Continue}, 32'h1);
        chk("t4_busy",         {31'd0, bus.busy},     32'h0);
        chk("t4_done",         {31'd0, bus.done},     32'h0);
        chk("t4_S_held",       {16'd0, bus.S},        32'h1234);
        step();
        chk("t4_stays_idle",   {31'd0, bus.busy},     32'h0);
        chk("t4_Run_stays",    {31'd0, bus.Run},      32'h1);

        // Asynchronous reset mid-pulse
        launch(5'd3);
        for (int i = 0; i < 5; i++) step();
        chk("t1_c6_Run_low", {31'd0, bus.Run}, 32'h0);
        rst_n = 1'b0;
        #1;
        chk("t1_S",    {16'd0, bus.S},        32'h0);
        chk("t1_Run",  {31'd0, bus.Run},      32'h1);
        chk("t1_Cont", {31'd0, bus.Continue}, 32'h1);
        chk("t1_busy", {31'd0, bus.busy},     32'h0);
        chk("t1_done", {31'd0, bus.done},     32'h0);
        chk("t1_idx",  {27'd0, bus.idx},      32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        launch(5'd1);
        step();
        chk("t1_ram_kept_S", {16'd0, bus.S}, 32'h1234);
        wait_done(20, "t1_rerun");

        // Busy lockout: write and start during a run are both dropped
        for (int i = 0; i < 5; i++) write_entry(4'(i), 2'b00, 16'h0000, 8'd3);
        write_entry(4'd5, 2'b11, 16'h0055, 8'd0);
        launch(5'd6);
        step();
        step();
        bus.wr_en   = 1'b1;
        bus.wr_addr = 4'd5;
        bus.wr_data = {2'b11, 16'h0AAA, 8'd0};
        bus.start   = 1'b1;
        step();
        bus.wr_en = 1'b0;
        bus.start = 1'b0;
        step();
        chk("t5_c5_idx",  {27'd0, bus.idx},  32'h1);
        chk("t5_c5_busy", {31'd0, bus.busy}, 32'h1);
        wait_done(100, "t5");
        chk("t5_old_entry_S", {16'd0, bus.S},   32'h0055);
        chk("t5_final_idx",   {27'd0, bus.idx}, 32'h6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
